// File: rtl/watch_time_reporter.sv
// Serialises a coherent hh:mm:ss[.cc] snapshot of the watch time as an ASCII line over a valid/ready byte stream.
// Optional centisecond field enabled by defining WATCH_REPORT_MSEC_EN.
module watch_time_reporter #(
    parameter logic [7:0] SEP_CHAR = 8'h3A,
    parameter logic [7:0] DOT_CHAR = 8'h2E,
    parameter bit         SEND_CR  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [6:0] msec,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       done
);

`ifdef WATCH_REPORT_MSEC_EN
    localparam int BODY_LEN = 11;
`else
    localparam int BODY_LEN = 8;
`endif
    localparam int         LINE_LEN = BODY_LEN + (SEND_CR ? 2 : 1);
    localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, FIN = 2'd2} state_t;

    // Tens digit by compare against multiples of ten; inputs are already clamped to 0..99.
    function automatic logic [3:0] tens_of(input logic [6:0] v);
        logic [3:0] t;
        t = 4'd0;
        for (int k = 1; k < 10; k++) begin
            if (v >= 7'(k * 10)) t = 4'(k);
        end
        return t;
    endfunction

    function automatic logic [7:0] ascii_tens(input logic [6:0] v);
        return 8'h30 + {4'd0, tens_of(v)};
    endfunction

    function automatic logic [7:0] ascii_ones(input logic [6:0] v);
        logic [6:0] ones;
        ones = v - 7'(tens_of(v)) * 7'd10;
        return 8'h30 + {1'b0, ones};
    endfunction

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [6:0] hr_q, hr_d, mn_q, mn_d, sc_q, sc_d;
    logic [6:0] hr_sat_s, mn_sat_s, sc_sat_s;
    logic [6:0] src_h_s, src_m_s, src_s_s;
    logic [3:0] sel_idx_s;
    logic [7:0] byte_s;

    assign hr_sat_s = (hour > 5'd23) ? 7'd23 : {2'b00, hour};
    assign mn_sat_s = (min  > 6'd59) ? 7'd59 : {1'b0, min};
    assign sc_sat_s = (sec  > 6'd59) ? 7'd59 : {1'b0, sec};

`ifdef WATCH_REPORT_MSEC_EN
    logic [6:0] cs_q, cs_d, cs_sat_s, src_c_s;
    assign cs_sat_s = (msec > 7'd99) ? 7'd99 : msec;
`else
    logic unused_msec_s;
    assign unused_msec_s = ^msec;
`endif

    // Byte source: live (clamped) inputs for the first byte, the snapshot for every later byte
    always_comb begin
        if (state_q == IDLE) begin
            src_h_s   = hr_sat_s;
            src_m_s   = mn_sat_s;
            src_s_s   = sc_sat_s;
            sel_idx_s = 4'd0;
        end else begin
            src_h_s   = hr_q;
            src_m_s   = mn_q;
            src_s_s   = sc_q;
            sel_idx_s = idx_q + 4'd1;
        end
`ifdef WATCH_REPORT_MSEC_EN
        src_c_s = (state_q == IDLE) ? cs_sat_s : cs_q;
`endif
    end

    // Line byte selected by position
    always_comb begin
        byte_s = 8'h0A;
        case (sel_idx_s)
            4'd0:    byte_s = ascii_tens(src_h_s);
            4'd1:    byte_s = ascii_ones(src_h_s);
            4'd2:    byte_s = SEP_CHAR;
            4'd3:    byte_s = ascii_tens(src_m_s);
            4'd4:    byte_s = ascii_ones(src_m_s);
            4'd5:    byte_s = SEP_CHAR;
            4'd6:    byte_s = ascii_tens(src_s_s);
            4'd7:    byte_s = ascii_ones(src_s_s);
`ifdef WATCH_REPORT_MSEC_EN
            4'd8:    byte_s = DOT_CHAR;
            4'd9:    byte_s = ascii_tens(src_c_s);
            4'd10:   byte_s = ascii_ones(src_c_s);
`endif
            default: begin
                if (SEND_CR && (sel_idx_s == 4'(BODY_LEN))) begin
                    byte_s = 8'h0D;
                end else begin
                    byte_s = 8'h0A;
                end
            end
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hr_d       = hr_q;
        mn_d       = mn_q;
        sc_d       = sc_q;
`ifdef WATCH_REPORT_MSEC_EN
        cs_d       = cs_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SEND;
                    idx_d      = 4'd0;
                    tx_data_d  = byte_s;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    hr_d       = hr_sat_s;
                    mn_d       = mn_sat_s;
                    sc_d       = sc_sat_s;
`ifdef WATCH_REPORT_MSEC_EN
                    cs_d       = cs_sat_s;
`endif
                end else begin
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = FIN;
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        idx_d      = idx_q + 4'd1;
                        tx_data_d  = byte_s;
                    end
                end else begin
                    tx_valid_d = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                idx_d   = 4'd0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                idx_d      = 4'd0;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State, snapshot and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hr_q       <= 7'd0;
            mn_q       <= 7'd0;
            sc_q       <= 7'd0;
`ifdef WATCH_REPORT_MSEC_EN
            cs_q       <= 7'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hr_q       <= hr_d;
            mn_q       <= mn_d;
            sc_q       <= sc_d;
`ifdef WATCH_REPORT_MSEC_EN
            cs_q       <= cs_d;
`endif
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
